// File: rtl/group_serial_sub_pkg.sv
// Types and helpers for the group-serial subtractor (optional compare flags: GROUP_SERIAL_SUB_CMP_EN).
`include "define.v"

package group_serial_sub_pkg;

    typedef enum logic [1:0] {
        SUB_ST_IDLE = `SUB_IDLE,
        SUB_ST_CALC = `SUB_CALC,
        SUB_ST_DONE = `SUB_DONE
    } sub_state_e;

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/define.v
// Shared operand-size and iterative-unit state macros used by the adder and subtractor.
`ifndef DEFINE_V
`define DEFINE_V

`define INPUTSIZE 32
`define GROUPSIZE 4

// Common state encodings for iterative units
`define SUB_IDLE 2'd0
`define SUB_CALC 2'd1
`define SUB_DONE 2'd2

`endif

// File: rtl/group_serial_sub_slice.sv
// Combinational GROUP-bit borrow-ripple subtract slice: {bo, d} = a - b - bin.
module group_sub #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             bin,
    output logic [GROUP-1:0] d,
    output logic             bo
);

    logic [GROUP:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int i = 0; i < GROUP; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    end

    assign bo = br[GROUP];

endmodule

// File: rtl/group_serial_sub.sv
// Group-serial subtractor: a - b - bin, one GROUP-bit slice per cycle behind valid/ready.
// Define GROUP_SERIAL_SUB_CMP_EN to add the lt/ltu/eq compare outputs.
`include "define.v"

module group_serial_sub
    import group_serial_sub_pkg::*;
#(
    parameter int WIDTH = `INPUTSIZE,
    parameter int GROUP = `GROUPSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
`ifdef GROUP_SERIAL_SUB_CMP_EN
    ,
    output logic             lt,
    output logic             ltu,
    output logic             eq
`endif
);

    localparam int N  = WIDTH / GROUP;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % GROUP != 0) begin : g_bad_group
            $error("group_serial_sub: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    sub_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [GROUP-1:0] a_s;
    logic [GROUP-1:0] b_s;
    logic [GROUP-1:0] d_s;
    logic             bo_s;
    logic             ovf_next;

    assign in_ready = (state == SUB_ST_IDLE) && !rst;

    // One slice instance, fed by the counter-selected operand slices
    assign a_s = a_q[int'(cnt)*GROUP +: GROUP];
    assign b_s = b_q[int'(cnt)*GROUP +: GROUP];

    group_sub #(
        .GROUP (GROUP)
    ) u_slice (
        .a   (a_s),
        .b   (b_s),
        .bin (borrow_q),
        .d   (d_s),
        .bo  (bo_s)
    );

    // On the last slice d_s carries the result MSB, so overflow is ready at the DONE transition
    assign ovf_next = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_s[GROUP-1] ^ a_q[WIDTH-1]);

`ifdef GROUP_SERIAL_SUB_CMP_EN
    logic eq_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SUB_ST_IDLE;
            cnt        <= '0;
            borrow_q   <= 1'b0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
`ifdef GROUP_SERIAL_SUB_CMP_EN
            eq_acc     <= 1'b0;
            lt         <= 1'b0;
            ltu        <= 1'b0;
            eq         <= 1'b0;
`endif
        end else begin
            case (state)
                SUB_ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt      <= '0;
`ifdef GROUP_SERIAL_SUB_CMP_EN
                        eq_acc   <= 1'b1;
`endif
                        state    <= SUB_ST_CALC;
                    end
                end
                SUB_ST_CALC: begin
                    diff[int'(cnt)*GROUP +: GROUP] <= d_s;
                    borrow_q <= bo_s;
`ifdef GROUP_SERIAL_SUB_CMP_EN
                    eq_acc   <= eq_acc & (d_s == '0);
`endif
                    if (cnt == LAST) begin
                        state      <= SUB_ST_DONE;
                        out_valid  <= 1'b1;
                        borrow_out <= bo_s;
                        overflow   <= ovf_next;
`ifdef GROUP_SERIAL_SUB_CMP_EN
                        ltu        <= bo_s;
                        lt         <= d_s[GROUP-1] ^ ovf_next;
                        eq         <= eq_acc & (d_s == '0);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SUB_ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= SUB_ST_IDLE;
                    end
                end
                default: begin
                    state     <= SUB_ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_group_serial_sub.sv
// Scoreboard bench for group_serial_sub at WIDTH=32, GROUP=4.
`timescale 1ns/1ps

module tb_group_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        overflow;
`ifdef GROUP_SERIAL_SUB_CMP_EN
    logic        lt;
    logic        ltu;
    logic        eq;
`endif

    always #5 clk = ~clk;

    group_serial_sub #(
        .WIDTH (32),
        .GROUP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
`ifdef GROUP_SERIAL_SUB_CMP_EN
        ,
        .lt         (lt),
        .ltu        (ltu),
        .eq         (eq)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        lt;
        logic        ltu;
        logic        eq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got diff 0x%08h expected no output at %0t", diff, $time);
                end else begin
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("borrow_out", 32'(borrow_out), 32'(e.bo));
                    chk("overflow", 32'(overflow), 32'(e.ov));
`ifdef GROUP_SERIAL_SUB_CMP_EN
                    chk("lt", 32'(lt), 32'(e.lt));
                    chk("ltu", 32'(ltu), 32'(e.ltu));
                    chk("eq", 32'(eq), 32'(e.eq));
`endif
                end
            end
        end
    end

    task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       input exp_t e, input bit chk_lat, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        bin = bi;
        in_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chk_lat) begin
            n = 0;
            while (!out_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", 32'(n), 32'd8);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_borrow_out", 32'(borrow_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        //             d             bo    ov    lt    ltu   eq
        run(32'd5, 32'd3, 1'b0, '{32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b1);
        wait_idle();
        run(32'd0, 32'd1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1);
        wait_idle();
        run(32'h10, 32'h0F, 1'b1, '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1);
        wait_idle();
        run(32'h8000_0000, 32'd1, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b1);
        wait_idle();
        run(32'd0, 32'd0, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}, 1'b0, 1'b1);
        wait_idle();
        run(32'd3, 32'hFFFF_FFFF, 1'b0, '{32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b1);
        wait_idle();
        run(32'h1234, 32'h1234, 1'b0, '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1);
        wait_idle();

        // Backpressure: results held, new requests ignored while DONE
        out_ready = 1'b0;
        run(32'h100, 32'd1, 1'b0, '{32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b1);
        a = 32'd7;
        b = 32'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_diff", diff, 32'hFF);
            chk("bp_borrow_out", 32'(borrow_out), 32'd0);
            chk("bp_overflow", 32'(overflow), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (12) @(posedge clk);
        #1;

        // Reset during the third CALC cycle aborts the operation
        run(32'h55, 32'h11, 1'b0, '{32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        chk("abort_out_valid_rst", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_rel", 32'(in_ready), 32'd1);
        chk("abort_diff_cleared", diff, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", 32'(out_valid), 32'd0);
        end
        run(32'd9, 32'd4, 1'b0, '{32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/group_serial_sub.md
# group_serial_sub

Group-serial subtractor: the inverse datapath of the group-parallel carry-lookahead adder. It computes `a - b - bin` one `GROUP`-bit slice per cycle, carrying a registered borrow between slices. It sits beside the adder in the ALU as a low-area subtract/compare unit behind a valid/ready handshake. It uses the same `define.v` width macros, so both units always agree on operand size.

## Interface
- `WIDTH`, default `` `INPUTSIZE ``: operand width in bits.
- `GROUP`, default `` `GROUPSIZE ``: bits processed per cycle. `WIDTH % GROUP == 0` is required. `N = WIDTH/GROUP` slices.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: unit can accept. High only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `a - b - bin` modulo 2^WIDTH.
- `borrow_out` output 1: 1 iff unsigned `a < b + bin`.
- `overflow` output 1: signed overflow, computed as `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.
- `lt`, `ltu`, `eq` output 1 each: present only with `GROUP_SERIAL_SUB_CMP_EN` (see Configuration).

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready = 1`.
  - On `in_valid && in_ready`: latch `a`, `b`, `bin` into the operand registers. Set the borrow register to `bin`, set slice counter `cnt = 0`, then go to CALC.
  - The `a`/`b` ports are ignored at all other times.
- **CALC:**
  - Each cycle, slice `cnt` computes `{bo, d} = a_s - b_s - borrow` over `GROUP` bits.
  - Write `d` into `diff[GROUP*cnt +: GROUP]`, set `borrow <= bo`, then `cnt <= cnt + 1`.
  - When `cnt == N-1`, the slice is written and the state goes to DONE.
- **DONE:**
  - `out_valid = 1`.
  - `borrow_out` equals the final borrow. `overflow` is computed from the latched `a[MSB]`, `b[MSB]` and `diff[MSB]`.
  - All outputs are held stable until `out_valid && out_ready`. On that handshake the state goes to IDLE.
- `in_valid` outside IDLE is ignored (no queuing).
- **Counter width:** `$clog2(N)`, minimum 1 bit. It never wraps within an operation.
- **Degenerate case `N == 1`:** CALC lasts exactly one cycle.
- **Outputs** are registered and never combinational from inputs, except `in_ready`, which is decoded from state.

## Timing
- Acceptance edge T. Slice i is written at edge T+1+i. DONE is entered at edge T+N.
- `out_valid` is high from cycle T+N. Latency is N cycles from the acceptance edge.
- The earliest output handshake is edge T+N+1 (with `out_ready` already high). `in_ready` rises the cycle after that. Peak throughput is one operation per N+2 cycles.
- **Backpressure:** `out_ready` low holds DONE indefinitely, with `diff` and the flags unchanged.
- **Reset:**
  - `rst` high at any edge sets state IDLE, `out_valid = 0`, and `diff`, `borrow_out`, `overflow` and the compare flags to 0. It also sets `cnt = 0` and borrow register = 0.
  - `in_ready` is forced to 0 while `rst` is high and reads 1 in the first cycle after release.
  - Reset mid-CALC or mid-DONE aborts the operation. No `out_valid` is produced for it.

## Configuration
- `GROUP_SERIAL_SUB_CMP_EN` defined:
  - Adds outputs `ltu = borrow_out`, `eq = (diff == 0)` and `lt = diff[MSB] ^ overflow`.
  - The flags are registered, valid with `out_valid`, and 0 at reset.
  - `eq` is accumulated per slice as an AND of slice-zero, so no WIDTH-wide compare is needed at DONE.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- `define.v` is the single source of `INPUTSIZE` and `GROUPSIZE`. Add the state encodings `SUB_IDLE`, `SUB_CALC` and `SUB_DONE` there as `` `define `` constants shared with future iterative units.
- **Sub-module `group_sub`:** combinational `GROUP`-bit borrow-ripple slice with inputs `a`, `b`, `bin` and outputs `d`, `bo`. It is instantiated once and reused every cycle via the slice mux.
- The top module holds the FSM, counter, operand registers, result register and flags.

## Test plan
All scenarios use WIDTH=32, GROUP=4 (N=8).
- `a=5`, `b=3`, `bin=0` → `diff=2`, `borrow_out=0`, `overflow=0`, with `out_valid` rising exactly 8 cycles after the acceptance edge.
- `a=0`, `b=1`, `bin=0` → `diff=0xFFFFFFFF`, `borrow_out=1`, `overflow=0`. A second run with `a=0x10`, `b=0x0F`, `bin=1` → `diff=0`, `borrow_out=0`.
- `a=0x80000000`, `b=1` → `diff=0x7FFFFFFF`, `overflow=1`, `borrow_out=0`.
- Hold `out_ready=0` for 5 cycles in DONE while driving `in_valid=1` with new operands → `diff` and flags stay constant and `in_ready=0`. The new operands are not taken until a fresh IDLE handshake.
- Assert `rst` at the 3rd CALC cycle → `out_valid` never rises. `in_ready=1` in the cycle after release, and the next operation `a=9`, `b=4` gives `diff=5`.
- With `GROUP_SERIAL_SUB_CMP_EN`: `a=3`, `b=0xFFFFFFFF` → `ltu=1`, `lt=0`, `eq=0`. Then `a=b=0x1234` → `eq=1`, `lt=0`, `ltu=0`.
